// File: rtl/store_result_tx.sv
// Snoops core store transactions, buffers captured words in a small FIFO and
// ships each word MSB-byte-first over a UART 8N1 line; the all-ones word ends the run.
module store_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH_LOG2   = 3,
    parameter bit          FILTER_EN    = 1'b0,
    parameter logic [31:0] RESULT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           data_out,
    input  logic                  data_write,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_count
);
    localparam int unsigned        DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned        CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [31:0]        SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
    logic [2:0]             bit_idx, bit_idx_next;
    logic [1:0]             byte_idx, byte_idx_next;
    logic [31:0]            shreg, shreg_next;
    logic                   word_is_sent, word_is_sent_next;
    logic                   tx_next, done_set, tick;

    logic                   write_d, sentinel_seen;
    logic [31:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic                   addr_ok, capture, full, pop, push, drop;

    // Capture on the rising edge of the store strobe only
    assign addr_ok = !FILTER_EN || (data_addr == RESULT_ADDR);
    assign capture = data_write && !write_d && addr_ok && !sentinel_seen;
    assign full    = (fifo_count == CNT_FULL);
    assign pop     = (state == IDLE) && (fifo_count != '0) && !done;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;
    assign tick    = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            write_d       <= 1'b0;
            sentinel_seen <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            write_d <= data_write;
            if (capture && (data_out == SENTINEL))
                sentinel_seen <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_out;
    end

    // Bit timer restarts on every state and bit boundary, so timing never drifts
    always_comb begin
        state_next        = state;
        bit_cnt_next      = bit_cnt + 1'b1;
        bit_idx_next      = bit_idx;
        byte_idx_next     = byte_idx;
        shreg_next        = shreg;
        word_is_sent_next = word_is_sent;
        done_set          = 1'b0;
        tx_next           = 1'b1;
        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                if (pop) begin
                    shreg_next        = mem[rd_ptr];
                    word_is_sent_next = (mem[rd_ptr] == SENTINEL);
                    byte_idx_next     = 2'd0;
                    state_next        = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    if (byte_idx != 2'd3) begin
                        byte_idx_next = byte_idx + 1'b1;
                        shreg_next    = {shreg[23:0], 8'h00};
                        state_next    = START;
                    end else begin
                        done_set   = word_is_sent;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Current byte always sits in the top 8 bits of the shift register
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[{2'b11, bit_idx_next}];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= 3'd0;
            byte_idx     <= 2'd0;
            word_is_sent <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            bit_idx      <= bit_idx_next;
            byte_idx     <= byte_idx_next;
            word_is_sent <= word_is_sent_next;
            tx           <= tx_next;
            busy         <= (state_next != IDLE);
            if (done_set)
                done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_next;
    end

endmodule

// File: tb/tb_store_result_tx.sv
// Scoreboard bench for store_result_tx: UART decoders pop expected words as
// frames arrive; directed stores exercise capture, FIFO, filter, sentinel and reset.
module tb_store_result_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_out = '0;
    logic        data_write_a = 1'b0;
    logic        data_write_f = 1'b0;

    logic        tx_a, busy_a, done_a, overflow_a;
    logic [1:0]  fifo_count_a;
    logic        tx_f, busy_f, done_f, overflow_f;
    logic [3:0]  fifo_count_f;

    store_result_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(1), .FILTER_EN(1'b0),
                      .RESULT_ADDR(32'h0)) dut_a (
        .clk(clk), .nrst(nrst), .data_addr(data_addr), .data_out(data_out),
        .data_write(data_write_a), .tx(tx_a), .busy(busy_a), .done(done_a),
        .overflow(overflow_a), .fifo_count(fifo_count_a)
    );

    store_result_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(3), .FILTER_EN(1'b1),
                      .RESULT_ADDR(32'h40)) dut_f (
        .clk(clk), .nrst(nrst), .data_addr(data_addr), .data_out(data_out),
        .data_write(data_write_f), .tx(tx_f), .busy(busy_f), .done(done_f),
        .overflow(overflow_f), .fifo_count(fifo_count_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_a[$];
    logic [31:0] exp_f[$];
    int tests = 0;
    int fails = 0;
    int t_drive = 0;

    int busy_cnt, first_busy, last_busy, first_done, first_tx_low, max_cnt;

    always @(negedge clk) begin
        if (busy_a) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        if (done_a && first_done < 0) first_done = cyc;
        if (nrst && !tx_a && first_tx_low < 0) first_tx_low = cyc;
        if (int'(fifo_count_a) > max_cnt) max_cnt = int'(fifo_count_a);
    end

    task automatic clear_stats();
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        first_done = -1; first_tx_low = -1; max_cnt = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic line(input bit which);
        return which ? tx_f : tx_a;
    endfunction

    // Called on the first start-bit sample; samples each bit mid-cell
    task automatic rx_byte(input bit which, output logic [7:0] b, output bit ok, output bit aborted);
        b = '0; ok = 1'b1; aborted = 1'b0;
        for (int off = 1; off <= 38; off++) begin
            @(negedge clk);
            if (!nrst) begin
                aborted = 1'b1;
                return;
            end
            if (off == 2 && line(which) !== 1'b0) ok = 1'b0;
            if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) b = {line(which), b[7:1]};
            if (off == 38 && line(which) !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic check_word(input bit which, input logic [31:0] w, input bit ok);
        logic [31:0] e;
        tests++;
        if ((which && exp_f.size() == 0) || (!which && exp_a.size() == 0)) begin
            fails++;
            $display("FAIL word_dut%0d: got %h (frame_ok=%0d), expected no word", which, w, ok);
        end else begin
            if (which) e = exp_f.pop_front();
            else       e = exp_a.pop_front();
            if (w !== e || !ok) begin
                fails++;
                $display("FAIL word_dut%0d: got %h (frame_ok=%0d), expected %h (frame_ok=1)", which, w, ok, e);
            end
        end
    endtask

    task automatic monitor(input bit which);
        logic [31:0] w;
        logic [7:0]  b;
        bit          ok, ab, wok;
        int          nb;
        w = '0; wok = 1'b1; nb = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                nb = 0; wok = 1'b1;
            end else if (line(which) === 1'b0) begin
                rx_byte(which, b, ok, ab);
                if (ab) begin
                    nb = 0; wok = 1'b1;
                end else begin
                    w = {w[23:0], b};
                    wok = wok & ok;
                    nb++;
                    if (nb == 4) begin
                        check_word(which, w, wok);
                        nb = 0; wok = 1'b1;
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    // Must be entered right after a negedge; returns on a negedge
    task automatic pulse(input bit which, input logic [31:0] addr, input logic [31:0] data, input int hold);
        data_addr = addr;
        data_out  = data;
        t_drive   = cyc;
        if (which) data_write_f = 1'b1;
        else       data_write_a = 1'b1;
        repeat (hold) @(negedge clk);
        data_write_a = 1'b0;
        data_write_f = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit which, input string name);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 8; i++) begin
            @(negedge clk);
            if ((which ? {busy_f, fifo_count_f != 4'd0, tx_f}
                       : {busy_a, fifo_count_a != 2'd0, tx_a}) == 3'b001) quiet++;
            else quiet = 0;
        end
        if (quiet < 8) begin
            tests++;
            fails++;
            $display("FAIL %s_idle_timeout: got busy after 3000 cycles, expected idle", name);
        end
    endtask

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        chk("reset_a", {tx_a, busy_a, done_a, overflow_a, fifo_count_a}, 6'b100000);
        chk("reset_f", {tx_f, busy_f, done_f, overflow_f, fifo_count_f}, 8'h80);
        nrst = 1'b1;
        @(negedge clk);

        // Single store held three cycles
        clear_stats();
        exp_a.push_back(32'h12345678);
        pulse(1'b0, 32'h0, 32'h12345678, 3);
        wait_idle(1'b0, "t1");
        chk("t1_latency", first_tx_low - t_drive, 2);
        chk("t1_busy_cycles", busy_cnt, 160);
        chk("t1_fifo_peak", max_cnt, 1);
        chk("t1_fifo_end", fifo_count_a, 0);

        // Three back-to-back stores
        clear_stats();
        exp_a.push_back(32'h00000001);
        exp_a.push_back(32'h00000002);
        exp_a.push_back(32'h00000003);
        pulse(1'b0, 32'h0, 32'h00000001, 1);
        pulse(1'b0, 32'h0, 32'h00000002, 1);
        pulse(1'b0, 32'h0, 32'h00000003, 1);
        wait_idle(1'b0, "t2");
        chk("t2_busy_cycles", busy_cnt, 480);
        chk("t2_span", last_busy - first_busy + 1, 482);
        chk("t2_overflow", overflow_a, 0);

        // Depth-2 FIFO overflow
        clear_stats();
        exp_a.push_back(32'h000000A1);
        exp_a.push_back(32'hCAFE0002);
        exp_a.push_back(32'h80000003);
        pulse(1'b0, 32'h0, 32'h000000A1, 1);
        pulse(1'b0, 32'h0, 32'hCAFE0002, 1);
        pulse(1'b0, 32'h0, 32'h80000003, 1);
        pulse(1'b0, 32'h0, 32'h55550004, 1);
        chk("t3_overflow", overflow_a, 1);
        chk("t3_fifo_peak", max_cnt, 2);
        wait_idle(1'b0, "t3");
        chk("t3_overflow_sticky", overflow_a, 1);

        // Reset during the second byte
        clear_stats();
        pulse(1'b0, 32'h0, 32'h11223344, 1);
        repeat (48) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("t6_reset_outputs", {tx_a, busy_a, done_a, overflow_a, fifo_count_a}, 6'b100000);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        clear_stats();
        exp_a.push_back(32'hA5C30F96);
        pulse(1'b0, 32'h0, 32'hA5C30F96, 1);
        wait_idle(1'b0, "t6");
        chk("t6_latency", first_tx_low - t_drive, 2);

        // Address filter
        exp_f.push_back(32'hAAAA5555);
        pulse(1'b1, 32'h40, 32'hAAAA5555, 1);
        pulse(1'b1, 32'h44, 32'hDEADBEEF, 1);
        wait_idle(1'b1, "t4");
        chk("t4_overflow_f", overflow_f, 0);

        // Sentinel ends the run
        clear_stats();
        exp_a.push_back(32'hFFFFFFFF);
        pulse(1'b0, 32'h0, 32'hFFFFFFFF, 2);
        chk("t5_done_early", done_a, 0);
        pulse(1'b0, 32'h0, 32'h00000009, 1);
        chk("t5_blocked_count", fifo_count_a, 0);
        wait_idle(1'b0, "t5");
        chk("t5_done", done_a, 1);
        chk("t5_done_timing", first_done - last_busy, 1);
        chk("t5_busy_cycles", busy_cnt, 160);
        chk("t5_overflow", overflow_a, 0);

        chk("left_a", exp_a.size(), 0);
        chk("left_f", exp_f.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_result_tx.md
Name: store_result_tx

Overview:
- Synthesizable counterpart of the simulation answer checker.
- Sits on the mips data-memory port beside datamem and snoops store transactions (DATA_ADDR, DATA_OUT, DATA_WRITE).
- Buffers each captured store word in a small FIFO and serializes it over a UART 8N1 line to a host PC, which compares it against its answer list.
- The sentinel word 32'hFFFFFFFF ends the run: it is transmitted, then the block raises done.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (min 2).
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words.
- FILTER_EN, 0, 1 = capture only stores whose address equals RESULT_ADDR.
- RESULT_ADDR, 32'h0000_0000, address matched when FILTER_EN=1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- nrst  in  1  reset, asynchronous, active-low.
- data_addr  in  32  core data address.
- data_out  in  32  core store data.
- data_write  in  1  core store strobe; may stay high for several cycles.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a word is being serialized.
- done  out  1  sticky; sentinel fully transmitted.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.
- fifo_count  out  DEPTH_LOG2+1  words currently buffered.

Behaviour:
- Reset values (nrst low, asynchronous): tx=1, busy=0, done=0, overflow=0, fifo_count=0; FIFO pointers 0; FSM IDLE; write_d=0; sentinel_seen=0.
- Capture:
  - write_d registers data_write.
  - A capture occurs on a cycle where data_write=1 and write_d=0, i.e. a rising edge. One store held high for N cycles = exactly one capture.
  - data_out is sampled in that same cycle.
  - If FILTER_EN=1, the capture also requires data_addr==RESULT_ADDR; non-matching stores are ignored.
- Sentinel:
  - A capture of 32'hFFFFFFFF is pushed like any other word and sets sentinel_seen.
  - While sentinel_seen=1, all further captures are ignored. They are not pushed and do not set overflow.
- FIFO:
  - Push happens in the capture cycle; fifo_count increments on the next edge.
  - Full (count==2**DEPTH_LOG2) with no pop in the same cycle: the capture is dropped and overflow is set.
  - Push and pop in the same cycle when full: the push is accepted and count is unchanged.
  - Pointers wrap modulo depth.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into a 32-bit shift register, set byte_idx=0, busy=1, go to START. A word pushed into an empty FIFO is therefore popped the cycle after the push, and tx falls one cycle after that.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. Bytes are taken from the word MSB first: byte_idx 0 = bits[31:24], byte_idx 3 = bits[7:0].
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - If byte_idx<3: increment byte_idx and go to START, with no idle gap between bytes.
    - Otherwise, word complete: go to IDLE, busy=0. If the word was 32'hFFFFFFFF, set done on that edge.
  - One word = 40*CLKS_PER_BIT cycles on the line.
- After done: the FSM stays in IDLE and tx stays 1. Captures stay blocked until reset.
- Reset mid-frame: tx returns to 1 immediately. The partial byte is abandoned, the FIFO is cleared, and the host sees a framing error.
- The bit timer is a counter 0..CLKS_PER_BIT-1 that restarts at every state entry. There is no drift across the 40 bits.

Test Plan:
- Store 32'h12345678 held for 3 cycles, CLKS_PER_BIT=4 -> exactly one word sent. Line bytes are 12,34,56,78, each with start bit 0 and stop bit 1. busy is high for 160 cycles. fifo_count goes 0→1→0.
- Three stores back-to-back on consecutive rising edges (00000001, 00000002, 00000003) -> all sent in order with no inter-word gap beyond the 1 IDLE pop cycle. overflow stays 0.
- DEPTH_LOG2=1, slow tx, 4 stores while the first is in flight -> FIFO holds 2 words, the 4th store sets overflow=1, and only stores 1-3 appear on tx.
- FILTER_EN=1, RESULT_ADDR=32'h40: stores to 0x40 (AAAA5555) and 0x44 (DEADBEEF) -> only AAAA5555 is transmitted.
- Store FFFFFFFF, then 00000009 -> FF,FF,FF,FF transmitted, done rises after the last stop bit, 00000009 is never sent, and fifo_count stays 0.
- nrst pulsed low during the 2nd byte of a word -> tx=1 immediately, all outputs at reset values, and a new store after release transmits correctly.
